// File: rtl/lcd_pkg.sv
// Shared defaults and FSM state type for the ROM-to-LCD pixel fetch path.
package lcd_pkg;
    localparam int ADDR_WIDTH_DEF = 17;
    localparam int DATA_WIDTH_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;
endpackage

// File: rtl/rom_pixel_fetch_if.sv
// Burst control, pixel ROM and LCD pixel stream signals of rom_pixel_fetch.
interface rom_pixel_fetch_if import lcd_pkg::*; #(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
    logic                  start_i;
    logic [ADDR_WIDTH-1:0] base_addr_i;
    logic [ADDR_WIDTH:0]   pixel_count_i;
    logic                  busy_o;
    logic                  done_o;
    logic [ADDR_WIDTH-1:0] rom_addr_o;
    logic [DATA_WIDTH-1:0] rom_data_i;
    logic [DATA_WIDTH-1:0] pix_data_o;
    logic                  pix_valid_o;
    logic                  pix_ready_i;
    logic                  pix_last_o;

    modport slave (
        input  start_i, base_addr_i, pixel_count_i, rom_data_i, pix_ready_i,
        output busy_o, done_o, rom_addr_o, pix_data_o, pix_valid_o, pix_last_o
    );

    modport master (
        output start_i, base_addr_i, pixel_count_i, rom_data_i, pix_ready_i,
        input  busy_o, done_o, rom_addr_o, pix_data_o, pix_valid_o, pix_last_o
    );
endinterface

// File: rtl/pix_fifo2.sv
// Two-entry valid/ready FIFO; output word is held in a register so it stays
// stable while the consumer stalls.
module pix_fifo2 #(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o,
    output logic         full_o,
    output logic         empty_o
);
    logic [1:0][W-1:0] mem_q;
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        cnt_q;
    logic              push;
    logic              pop;

    assign full_o      = (cnt_q == 2'd2);
    assign empty_o     = (cnt_q == 2'd0);
    assign in_ready_o  = ~full_o;
    assign out_valid_o = ~empty_o;
    assign out_data_o  = mem_q[rd_ptr_q];
    assign push        = in_valid_i & in_ready_o;
    assign pop         = out_valid_o & out_ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= in_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

// File: rtl/rom_pixel_fetch.sv
// Streams a burst of RGB565 words from a 1-cycle-latency pixel ROM into a
// valid/ready pixel stream, with flow control so no ROM word is ever dropped.
module rom_pixel_fetch import lcd_pkg::*; #(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    rom_pixel_fetch_if.slave  bus
);
    localparam logic [ADDR_WIDTH:0] CNT_ZERO = '0;
    localparam logic [ADDR_WIDTH:0] CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

    fetch_state_e          state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [ADDR_WIDTH-1:0] last_addr_q;
    logic [ADDR_WIDTH:0]   remain_q;
    logic [ADDR_WIDTH:0]   remain_d;
    logic                  rd_vld_q;
    logic                  rd_last_q;
    logic                  done_q;

    logic                  fifo_in_ready;
    logic                  fifo_out_valid;
    logic [DATA_WIDTH:0]   fifo_out_data;
    logic                  fifo_full;
    logic                  fifo_empty;

    logic                  pop_w;
    logic                  issue_w;
    logic                  issue_last_w;
    logic [1:0]            occ_w;
    logic [2:0]            used_w;
    logic [2:0]            avail_w;

    // A word popped this cycle frees its slot in time for a read issued now,
    // which is what allows one pixel per clock with only two entries.
    assign pop_w        = fifo_out_valid & bus.pix_ready_i;
    assign occ_w        = {fifo_full, ~fifo_full & ~fifo_empty};
    assign used_w       = {1'b0, occ_w} + {2'b00, rd_vld_q};
    assign avail_w      = 3'd2 + {2'b00, pop_w};
    assign issue_w      = (state_q == FETCH) && (remain_q != CNT_ZERO) && (used_w < avail_w);
    assign issue_last_w = issue_w && (remain_q == CNT_ONE);
    assign addr_d       = addr_q + 1'b1;
    assign remain_d     = remain_q - CNT_ONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            last_addr_q <= '0;
            remain_q    <= '0;
            rd_vld_q    <= 1'b0;
            rd_last_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            rd_vld_q  <= issue_w;
            rd_last_q <= issue_last_w;
            if (issue_w) begin
                last_addr_q <= addr_q;
                addr_q      <= addr_d;
                remain_q    <= remain_d;
            end
            case (state_q)
                IDLE: begin
                    if (bus.start_i) begin
                        if (bus.pixel_count_i == CNT_ZERO) begin
                            done_q <= 1'b1;
                        end else begin
                            addr_q   <= bus.base_addr_i;
                            remain_q <= bus.pixel_count_i;
                            state_q  <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    if (issue_last_w) state_q <= DRAIN;
                end
                DRAIN: begin
                    if (pop_w && fifo_out_data[DATA_WIDTH]) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // The ROM registers the address itself, so the issued address is driven
    // straight out; between reads the last issued address is held.
    assign bus.rom_addr_o  = issue_w ? addr_q : last_addr_q;
    assign bus.busy_o      = (state_q != IDLE);
    assign bus.done_o      = done_q;
    assign bus.pix_valid_o = fifo_out_valid;
    assign bus.pix_data_o  = fifo_out_data[DATA_WIDTH-1:0];
    assign bus.pix_last_o  = fifo_out_valid & fifo_out_data[DATA_WIDTH];

    pix_fifo2 #(.W(DATA_WIDTH + 1)) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (rd_vld_q),
        .in_ready_o  (fifo_in_ready),
        .in_data_i   ({rd_last_q, bus.rom_data_i}),
        .out_valid_o (fifo_out_valid),
        .out_ready_i (bus.pix_ready_i),
        .out_data_o  (fifo_out_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    a_no_drop: assert property (@(posedge clk) disable iff (!rst_n) rd_vld_q |-> fifo_in_ready);
endmodule

// File: tb/tb_rom_pixel_fetch.sv
// Scoreboard bench for rom_pixel_fetch: directed bursts push expected pixels,
// a negedge monitor pops and compares every accepted pixel.
module tb_rom_pixel_fetch;
    typedef struct packed {
        logic [15:0] data;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   nt = 0;
    int   nf = 0;

    exp_t exp_q[$];
    int   hs_cnt = 0;
    int   done_cnt = 0;
    int   done_cyc = 0;
    int   last_hs_cyc = 0;
    int   first_vld_cyc = 0;
    int   acc_cyc = 0;
    bit   first_pend = 1'b0;
    bit   busy_seen = 1'b0;
    bit   valid_seen = 1'b0;
    bit   prev_stall = 1'b0;
    logic [15:0] prev_data;
    logic        prev_last;

    rom_pixel_fetch_if #(.ADDR_WIDTH(17), .DATA_WIDTH(16)) bus ();

    rom_pixel_fetch #(.ADDR_WIDTH(17), .DATA_WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] rom_word(input logic [16:0] a);
        return a[15:0] ^ {a[16], 15'b0} ^ 16'h5A00;
    endfunction

    // Registered ROM: data for the address seen at an edge appears after it.
    always @(posedge clk) bus.rom_data_i <= rom_word(bus.rom_addr_o);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nt++;
        if (act !== exp) begin
            nf++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        nt++;
        nf++;
        $display("FAIL %s: timed out waiting for DUT", nm);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            exp_t e;
            if (bus.busy_o) busy_seen = 1'b1;
            if (bus.pix_valid_o) valid_seen = 1'b1;
            if (prev_stall)
                chk("stall_stable", {bus.pix_valid_o, bus.pix_last_o, bus.pix_data_o},
                    {1'b1, prev_last, prev_data});
            if (bus.pix_valid_o && first_pend) begin
                first_vld_cyc = cyc;
                first_pend    = 1'b0;
            end
            if (bus.pix_valid_o && bus.pix_ready_i) begin
                if (exp_q.size() == 0) begin
                    nt++;
                    nf++;
                    $display("FAIL unexpected_pixel: got %0h expected none", bus.pix_data_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("pix_data", bus.pix_data_o, e.data);
                    chk("pix_last", bus.pix_last_o, e.last);
                end
                hs_cnt++;
                if (bus.pix_last_o) last_hs_cyc = cyc;
            end
            if (bus.done_o) begin
                done_cnt++;
                done_cyc = cyc;
            end
            prev_stall = bus.pix_valid_o & ~bus.pix_ready_i;
            prev_data  = bus.pix_data_o;
            prev_last  = bus.pix_last_o;
        end
    end

    task automatic push(input logic [15:0] d, input logic l);
        exp_q.push_back('{data: d, last: l});
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic do_start(input logic [16:0] base, input logic [17:0] cnt);
        first_pend        = 1'b1;
        bus.start_i       = 1'b1;
        bus.base_addr_i   = base;
        bus.pixel_count_i = cnt;
        @(posedge clk);
        #1;
        acc_cyc     = cyc;
        bus.start_i = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int d0, input bit toggle);
        for (int k = 0; k < 200 && done_cnt == d0; k++) begin
            @(posedge clk);
            #1;
            if (toggle) bus.pix_ready_i = ~bus.pix_ready_i;
        end
        if (done_cnt == d0) fail_now(nm);
        bus.pix_ready_i = 1'b1;
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_busy"},  bus.busy_o,      1'b0);
        chk({nm, "_done"},  bus.done_o,      1'b0);
        chk({nm, "_valid"}, bus.pix_valid_o, 1'b0);
        chk({nm, "_last"},  bus.pix_last_o,  1'b0);
        chk({nm, "_addr"},  bus.rom_addr_o,  17'h0);
        chk({nm, "_data"},  bus.pix_data_o,  16'h0);
    endtask

    initial begin
        int d0;
        int h0;
        rst_n             = 1'b0;
        bus.start_i       = 1'b0;
        bus.base_addr_i   = '0;
        bus.pixel_count_i = '0;
        bus.pix_ready_i   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic burst, ready held high
        for (int i = 0; i < 4; i++) push(16'h5A10 + 16'(i), i == 3);
        d0 = done_cnt;
        do_start(17'h00010, 18'd4);
        wait_done("A_done", d0, 1'b0);
        chk("A_first_latency", first_vld_cyc - acc_cyc, 2);
        chk("A_done_after_last", done_cyc - last_hs_cyc, 1);
        chk("A_done_pulses", done_cnt - d0, 1);
        chk("A_drained", exp_q.size(), 0);

        // Ready toggling every cycle
        for (int i = 0; i < 8; i++) push(16'h5B23 + 16'(i), i == 7);
        d0 = done_cnt;
        do_start(17'h00123, 18'd8);
        wait_done("B_done", d0, 1'b1);
        chk("B_done_after_last", done_cyc - last_hs_cyc, 1);
        chk("B_drained", exp_q.size(), 0);

        // Zero-length burst
        repeat (2) @(posedge clk);
        #1;
        busy_seen  = 1'b0;
        valid_seen = 1'b0;
        d0 = done_cnt;
        do_start(17'h00055, 18'd0);
        wait_done("D_done", d0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("D_busy_seen", busy_seen, 1'b0);
        chk("D_valid_seen", valid_seen, 1'b0);
        chk("D_done_pulses", done_cnt - d0, 1);

        // Start while busy is ignored
        for (int i = 0; i < 6; i++) push(16'h5800 + 16'(i), i == 5);
        d0 = done_cnt;
        do_start(17'h00200, 18'd6);
        @(posedge clk);
        #1;
        do_start(17'h00007, 18'd3);
        wait_done("E_done", d0, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        chk("E_done_pulses", done_cnt - d0, 1);
        chk("E_drained", exp_q.size(), 0);
        chk("E_idle", bus.busy_o, 1'b0);

        // Reset after 3 of 10 pixels
        for (int i = 0; i < 10; i++) push(16'h5A40 + 16'(i), i == 9);
        h0 = hs_cnt;
        do_start(17'h00040, 18'd10);
        for (int k = 0; k < 100 && (hs_cnt - h0) < 3; k++) begin
            @(posedge clk);
            #1;
        end
        if ((hs_cnt - h0) < 3) fail_now("F_three_pixels");
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("F_async");
        exp_q.delete();
        d0 = done_cnt;
        repeat (3) @(posedge clk);
        #1;
        rst_n      = 1'b1;
        busy_seen  = 1'b0;
        valid_seen = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("F_no_done", done_cnt - d0, 0);
        chk("F_no_pixels", valid_seen, 1'b0);
        chk("F_no_busy", busy_seen, 1'b0);

        // Address wrap, also proves operation after reset release
        push(16'h25FE, 1'b0);
        push(16'h25FF, 1'b0);
        push(16'h5A00, 1'b0);
        push(16'h5A01, 1'b1);
        d0 = done_cnt;
        do_start(17'h1FFFE, 18'd4);
        wait_done("C_done", d0, 1'b0);
        chk("C_first_latency", first_vld_cyc - acc_cyc, 2);
        chk("C_done_after_last", done_cyc - last_hs_cyc, 1);
        chk("C_drained", exp_q.size(), 0);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", nt, nf);
        $finish;
    end
endmodule
